// File: rtl/wishbone_arbiter_2m1s.sv
// wishbone_arbiter_2m1s: merges data (m0) and instruction (m1) Wishbone masters onto one slave bus
// Ports: clk, rst (sync, active-high); m0_* data master (priority), m1_* instruction master;
// s_* shared slave bus; bus_err_o sticky flag raised when a granted transaction times out.
module wishbone_arbiter_2m1s #(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic        bus_err_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GNT_D = 2'd1;
    localparam logic [1:0] GNT_I = 2'd2;

    logic [1:0] state;
    logic [3:0] starve_cnt;
    logic [7:0] to_cnt;
    logic       req0, req1, pick_i, g0, g1, gstb, gcyc, ack_raw, to_hit, done;

    always_comb begin
        req0      = m0_cyc_i & m0_stb_i;
        req1      = m1_cyc_i & m1_stb_i;
        pick_i    = req1 & (~req0 | (starve_cnt == 4'(STARVE_LIMIT)));
        g0        = state == GNT_D;
        g1        = state == GNT_I;
        gstb      = (g0 & m0_stb_i) | (g1 & m1_stb_i);
        gcyc      = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
        ack_raw   = s_ack_i & gstb;
        // a slave ack on the last allowed cycle wins over the timeout; an abort suppresses it
        to_hit    = gcyc & ~ack_raw & (to_cnt == 8'(TIMEOUT - 1));
        done      = ack_raw | ~gcyc | to_hit;
        s_addr_o  = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
        s_data_o  = g0 ? m0_data_i : g1 ? m1_data_i : '0;
        s_we_o    = g0 ? m0_we_i : g1 ? m1_we_i : 1'b0;
        s_sel_o   = g0 ? m0_sel_i : g1 ? m1_sel_i : '0;
        s_stb_o   = gstb & ~to_hit;
        s_cyc_o   = gcyc & ~to_hit;
        m0_ack_o  = g0 & (ack_raw | to_hit);
        m1_ack_o  = g1 & (ack_raw | to_hit);
        m0_data_o = (g0 & ~to_hit) ? s_data_i : '0;
        m1_data_o = (g1 & ~to_hit) ? s_data_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            to_cnt     <= '0;
            bus_err_o  <= 1'b0;
        end else begin
            if (to_hit) bus_err_o <= 1'b1;
            if (state == IDLE) begin
                to_cnt <= '0;
                if (pick_i) begin
                    state      <= GNT_I;
                    starve_cnt <= '0;
                end else if (req0) begin
                    state      <= GNT_D;
                    starve_cnt <= req1 ? starve_cnt + 4'd1 : '0;
                end
            end else begin
                to_cnt <= ack_raw ? '0 : to_cnt + 8'd1;
                if (done) state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_wishbone_arbiter_2m1s.sv
// tb_wishbone_arbiter_2m1s: self-checking bench with a slave model and an ack scoreboard
module tb_wishbone_arbiter_2m1s;
    localparam int TO = 16;
    localparam int SL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o, m1_addr_i, m1_data_i, m1_data_o;
    logic        m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o;
    logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, bus_err_o;

    wishbone_arbiter_2m1s #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
        .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
        .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m1;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        bit          r0;
        bit          r1;
        int          wt;
        bit          hang;
        logic [31:0] rd;
        bit          err;
    } vec_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   m0_left = 0;
    int   m1_left = 0;
    bit   m0_hold = 0;
    bit   sl_active = 0;
    bit   sl_hang = 0;
    int   sl_wait = 0;
    int   scnt = 0;
    bit   ack0, ack1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        m0_cyc_i = (m0_left > 0) || m0_hold;
        m0_stb_i = m0_cyc_i;
        m1_cyc_i = m1_left > 0;
        m1_stb_i = m1_cyc_i;
        s_ack_i  = 1'b0;
        #1;
        if (!sl_active && s_stb_o) begin
            sl_active = 1;
            scnt      = 0;
        end
        s_ack_i = sl_active && !sl_hang && scnt == sl_wait;
        if (sl_active) scnt++;
        @(negedge clk);
        ack0 = m0_ack_o;
        ack1 = m1_ack_o;
        if (ack0 || ack1) begin
            if (q.size() == 0) begin
                check("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
            end else begin
                e = q.pop_front();
                check("ack_master", {30'b0, ack1, ack0}, e.m1 ? 32'd2 : 32'd1);
                check(e.m1 ? "m1_data" : "m0_data", e.m1 ? m1_data_o : m0_data_o, e.data);
            end
        end
        if (ack0 && m0_left > 0) m0_left--;
        if (ack1 && m1_left > 0) m1_left--;
        if (sl_active && (!s_cyc_o || ack0 || ack1)) sl_active = 0;
    endtask

    task automatic push(input bit m1, input logic [31:0] d);
        exp_t e;
        e.m1   = m1;
        e.data = d;
        q.push_back(e);
    endtask

    task automatic run_txns(input int n0, input int n1, input int bound);
        m0_left = n0;
        m1_left = n1;
        for (int c = 0; c < bound && (m0_left > 0 || m1_left > 0); c++) tick();
        check("txns_left", m0_left + m1_left, 32'd0);
        m0_left = 0;
        m1_left = 0;
        tick();
        tick();
        check("idle_cyc", {31'b0, s_cyc_o}, 32'd0);
        check("queue_drained", q.size(), 32'd0);
        q.delete();
    endtask

    task automatic measure_timeout();
        int ncyc = 0;
        bit seen = 0;
        sl_hang = 1;
        push(1, 32'd0);
        m1_left = 1;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            if (s_cyc_o) ncyc++;
            if (ack1) begin
                seen = 1;
                check("to_stb_forced", {30'b0, s_stb_o, s_cyc_o}, 32'd0);
            end
        end
        check("to_seen", {31'b0, seen}, 32'd1);
        check("to_latency", ncyc, TO - 1);
        m1_left = 0;
        tick();
        check("to_single_pulse", {31'b0, ack1}, 32'd0);
        check("to_bus_err", {31'b0, bus_err_o}, 32'd1);
        sl_hang = 0;
    endtask

    vec_t vecs[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 2, 0, 32'hDEADBEEF, 0};
        vecs[1] = '{0, 1, 0, 0, 32'h0BADF00D, 0};
        vecs[2] = '{1, 1, 1, 0, 32'hCAFE0001, 0};
        vecs[3] = '{0, 1, TO - 1, 0, 32'h5555AAAA, 0};
        vecs[4] = '{1, 0, TO - 2, 0, 32'h13579BDF, 0};
        vecs[5] = '{1, 0, 0, 1, 32'hFFFF0000, 1};
        vecs[6] = '{0, 1, 3, 0, 32'h24681357, 1};

        rst = 1;
        m0_addr_i = 32'h0000_1000; m0_data_i = 32'h0; m0_we_i = 0; m0_sel_i = 4'hF;
        m1_addr_i = 32'h0000_2000; m1_data_i = 32'h0; m1_we_i = 0; m1_sel_i = 4'hF;
        m0_stb_i = 0; m0_cyc_i = 0; m1_stb_i = 0; m1_cyc_i = 0;
        s_ack_i = 0; s_data_i = 32'hA5A5_5A5A;
        m0_hold = 1;
        m1_left = 1;
        tick();
        tick();
        check("rst_s_bus", {s_addr_o[7:0], s_data_o[7:0], s_sel_o, 1'b0, s_we_o, s_stb_o, s_cyc_o}, 32'd0);
        check("rst_acks", {29'b0, bus_err_o, m1_ack_o, m0_ack_o}, 32'd0);
        check("rst_m0_data", m0_data_o, 32'd0);
        check("rst_m1_data", m1_data_o, 32'd0);
        m0_hold = 0; m1_left = 0;
        m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        rst = 0;

        for (int i = 0; i < 7; i++) begin
            sl_wait  = vecs[i].wt;
            sl_hang  = vecs[i].hang;
            s_data_i = vecs[i].rd;
            if (vecs[i].r0) push(0, vecs[i].hang ? 32'd0 : vecs[i].rd);
            if (vecs[i].r1) push(1, vecs[i].hang ? 32'd0 : vecs[i].rd);
            run_txns(vecs[i].r0, vecs[i].r1, 100);
            check("vec_bus_err", {31'b0, bus_err_o}, {31'b0, vecs[i].err});
        end
        sl_hang = 0;

        rst = 1;
        tick();
        rst = 0;
        check("rst_clears_err", {31'b0, bus_err_o}, 32'd0);

        begin
            int n = 0;
            sl_wait  = 0;
            s_data_i = 32'h0000_7777;
            push(0, 32'h0000_7777);
            m0_left = 1;
            for (int c = 0; c < 10 && m0_left > 0; c++) begin
                tick();
                n++;
            end
            check("req_to_ack_cycles", n, 32'd2);
            tick();
            check("idle_gap", {31'b0, s_cyc_o}, 32'd0);
        end

        s_data_i = 32'h0000_5151;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < SL; d++) push(0, 32'h0000_5151);
            push(1, 32'h0000_5151);
        end
        push(0, 32'h0000_5151);
        push(0, 32'h0000_5151);
        run_txns(2 * SL + 2, 2, 200);

        s_data_i = 32'hBEEF_0001;
        measure_timeout();

        sl_hang = 1;
        m0_we_i = 1; m0_sel_i = 4'b0011; m0_data_i = 32'h12345678;
        m0_hold = 1;
        tick(); tick(); tick();
        check("wr_cyc", {31'b0, s_cyc_o}, 32'd1);
        check("wr_we", {31'b0, s_we_o}, 32'd1);
        check("wr_sel", {28'b0, s_sel_o}, 32'h3);
        check("wr_data", s_data_o, 32'h12345678);
        check("wr_addr", s_addr_o, 32'h0000_1000);
        m0_hold = 0;
        begin
            int acks = 0;
            for (int c = 0; c < 4; c++) begin
                tick();
                if (ack0 || ack1) acks++;
            end
            check("abort_no_ack", acks, 32'd0);
        end
        check("abort_idle", {31'b0, s_cyc_o}, 32'd0);
        check("err_sticky", {31'b0, bus_err_o}, 32'd1);
        m0_we_i = 0; m0_sel_i = 4'hF; m0_data_i = 32'h0;

        m0_hold = 1;
        tick(); tick(); tick();
        check("pre_rst_granted", {31'b0, s_cyc_o}, 32'd1);
        rst = 1;
        tick();
        check("mid_rst_s_bus", {s_addr_o[7:0], s_data_o[7:0], s_sel_o, 1'b0, s_we_o, s_stb_o, s_cyc_o}, 32'd0);
        check("mid_rst_acks", {29'b0, bus_err_o, m1_ack_o, m0_ack_o}, 32'd0);
        check("mid_rst_m0_data", m0_data_o, 32'd0);
        m0_hold = 0; m0_cyc_i = 0; m0_stb_i = 0;
        rst = 0;
        sl_hang = 0;
        tick();
        measure_timeout();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
